// File: rtl/tinyv_pkg.sv
// ============================================================================
//  Module      : tinyv_pkg
//  Description : Shared TinyV decode definitions: RV32I opcodes, immediate
//                format selector and the ID/EX pipeline payload.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package tinyv_pkg;

    localparam int c_XLEN   = `DATA_WIDTH;
    localparam int c_REG_AW = `REG_ADDR_WIDTH;

    // RV32I base opcodes handled by the decode stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [c_XLEN-1:0]   pc;
        logic [31:0]         instr;
        logic [c_XLEN-1:0]   rs1_val;
        logic [c_XLEN-1:0]   rs2_val;
        logic [c_XLEN-1:0]   imm;
        logic [c_REG_AW-1:0] rd;
        logic                illegal;
    } id_ex_t;

endpackage : tinyv_pkg

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational RV32I immediate generator. Selects the
//                immediate layout by format and sign-extends from instr[31].
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_gen
    import tinyv_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic [31:0]           i_instr,
    input  imm_fmt_e              i_fmt,
    output logic [DATA_WIDTH-1:0] o_imm
);

    logic [31:0] w_imm32;

    // Reassemble the scattered immediate fields for each instruction format
    always_comb begin
        w_imm32 = '0;
        case (i_fmt)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Signed size cast widens to the datapath while keeping the sign
    assign o_imm = DATA_WIDTH'($signed(w_imm32));

endmodule : imm_gen

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// ============================================================================
//  Module      : operand_fetch_stage
//  Description : TinyV decode / operand-fetch stage. Decodes the instruction,
//                drives regfile read addresses, resolves operands through
//                EX/WB forwarding, stalls on load-use and registers the
//                result in a valid/ready ID/EX register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_fetch_stage
    import tinyv_pkg::*;
#(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    output logic [REG_ADDR_WIDTH-1:0] addr_rs1,
    output logic [REG_ADDR_WIDTH-1:0] addr_rs2,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic                      ex_fwd_valid,
    input  logic                      ex_fwd_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] ex_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     ex_fwd_data,
    input  logic                      wb_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_pc,
    output logic [31:0]               out_instr,
    output logic [DATA_WIDTH-1:0]     out_rs1_val,
    output logic [DATA_WIDTH-1:0]     out_rs2_val,
    output logic [DATA_WIDTH-1:0]     out_imm,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_illegal
);

    logic [6:0]                w_opcode;
    logic [REG_ADDR_WIDTH-1:0] w_rs1;
    logic [REG_ADDR_WIDTH-1:0] w_rs2;
    logic                      w_uses_rs1;
    logic                      w_uses_rs2;
    logic                      w_writes_rd;
    logic                      w_illegal;
    imm_fmt_e                  w_fmt;
    logic [DATA_WIDTH-1:0]     w_imm;
    logic [DATA_WIDTH-1:0]     w_rs1_val;
    logic [DATA_WIDTH-1:0]     w_rs2_val;
    logic                      w_hazard;
    logic                      w_advance;
    logic                      w_take;
    id_ex_t                    w_next;
    id_ex_t                    r_payload;
    logic                      r_valid;

    assign w_opcode = in_instr[6:0];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign addr_rs1 = w_rs1;
    assign addr_rs2 = w_rs2;

    // Opcode decode: source usage, destination write, immediate format
    always_comb begin
        w_uses_rs1  = 1'b0;
        w_uses_rs2  = 1'b0;
        w_writes_rd = 1'b0;
        w_illegal   = 1'b0;
        w_fmt       = IMM_NONE;
        case (w_opcode)
            OPC_OP:     begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_writes_rd = 1'b1; end
            OPC_OP_IMM: begin w_uses_rs1 = 1'b1; w_writes_rd = 1'b1; w_fmt = IMM_I; end
            OPC_LOAD:   begin w_uses_rs1 = 1'b1; w_writes_rd = 1'b1; w_fmt = IMM_I; end
            OPC_STORE:  begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_fmt = IMM_S; end
            OPC_BRANCH: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_fmt = IMM_B; end
            OPC_JALR:   begin w_uses_rs1 = 1'b1; w_writes_rd = 1'b1; w_fmt = IMM_I; end
            OPC_JAL:    begin w_writes_rd = 1'b1; w_fmt = IMM_J; end
            OPC_LUI:    begin w_writes_rd = 1'b1; w_fmt = IMM_U; end
            OPC_AUIPC:  begin w_writes_rd = 1'b1; w_fmt = IMM_U; end
            default:    w_illegal = 1'b1;
        endcase
    end

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .i_instr (in_instr),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

    // x0 reads zero; a completed EX result beats the older WB value, which
    // must be bypassed because the regfile write lands on the same edge
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [REG_ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0]     rf_val,
        input logic                      ex_ok,
        input logic [REG_ADDR_WIDTH-1:0] ex_rd,
        input logic [DATA_WIDTH-1:0]     ex_val,
        input logic                      wb_ok,
        input logic [REG_ADDR_WIDTH-1:0] wb_idx,
        input logic [DATA_WIDTH-1:0]     wb_val
    );
        if (idx == '0)                     return '0;
        else if (ex_ok && (ex_rd == idx))  return ex_val;
        else if (wb_ok && (wb_idx == idx)) return wb_val;
        else                               return rf_val;
    endfunction

    // Operand resolution for both sources
    always_comb begin
        w_rs1_val = resolve(w_rs1, rs1_data, ex_fwd_valid && !ex_fwd_is_load, ex_fwd_rd,
                            ex_fwd_data, wb_we, wb_rd, wb_data);
        w_rs2_val = resolve(w_rs2, rs2_data, ex_fwd_valid && !ex_fwd_is_load, ex_fwd_rd,
                            ex_fwd_data, wb_we, wb_rd, wb_data);
    end

    // A load in EX whose data a used source needs forces a one-cycle bubble
    assign w_hazard = in_valid && ex_fwd_valid && ex_fwd_is_load && (ex_fwd_rd != '0) &&
                      ((w_uses_rs1 && (w_rs1 == ex_fwd_rd)) ||
                       (w_uses_rs2 && (w_rs2 == ex_fwd_rd)));

    assign w_advance = !r_valid || out_ready;
    assign w_take    = in_valid && !w_hazard;
    assign in_ready  = reset && w_advance && !w_hazard && !flush;

    // Payload captured into the ID/EX register
    always_comb begin
        w_next         = '0;
        w_next.pc      = in_pc;
        w_next.instr   = in_instr;
        w_next.rs1_val = w_rs1_val;
        w_next.rs2_val = w_rs2_val;
        w_next.imm     = w_illegal ? '0 : w_imm;
        w_next.rd      = w_writes_rd ? in_instr[11:7] : '0;
        w_next.illegal = w_illegal;
    end

    // ID/EX register: flush kills, stall holds, hazard inserts a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
        end else if (w_advance) begin
            r_valid <= w_take;
            if (w_take) begin
                r_payload <= w_next;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_payload.pc;
    assign out_instr   = r_payload.instr;
    assign out_rs1_val = r_payload.rs1_val;
    assign out_rs2_val = r_payload.rs2_val;
    assign out_imm     = r_payload.imm;
    assign out_rd      = r_payload.rd;
    assign out_illegal = r_payload.illegal;

endmodule : operand_fetch_stage

`default_nettype wire

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage of the TinyV core, directly upstream of the register file and feeding execute.
- Decodes the fetched instruction and drives rs1/rs2 read addresses to the register file.
- Resolves operands through forwarding, detects load-use hazards and generates the immediate.
- Captures the result in a valid/ready ID/EX pipeline register.

Parameters:
- DATA_WIDTH, 32, datapath width; default equals `DATA_WIDTH.
- REG_ADDR_WIDTH, 5, register index width; default equals `REG_ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  RV32I instruction word.
- in_pc  in  DATA_WIDTH  PC of in_instr.
- addr_rs1  out  REG_ADDR_WIDTH  regfile read address, instr[19:15]; combinational.
- addr_rs2  out  REG_ADDR_WIDTH  regfile read address, instr[24:20]; combinational.
- rs1_data  in  DATA_WIDTH  regfile read data; same-cycle, returns 0 for x0.
- rs2_data  in  DATA_WIDTH  regfile read data.
- ex_fwd_valid  in  1  EX stage holds an instruction that writes rd.
- ex_fwd_is_load  in  1  EX instruction is a load; its data is not yet available.
- ex_fwd_rd  in  REG_ADDR_WIDTH  EX destination.
- ex_fwd_data  in  DATA_WIDTH  EX result.
- wb_we  in  1  writeback write enable, same signal driven into the regfile.
- wb_rd  in  REG_ADDR_WIDTH  writeback destination.
- wb_data  in  DATA_WIDTH  writeback data.
- flush  in  1  branch redirect: kill the in-flight and incoming instruction.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute accepts this cycle.
- out_pc  out  DATA_WIDTH  captured PC.
- out_instr  out  32  captured instruction.
- out_rs1_val  out  DATA_WIDTH  resolved rs1 operand.
- out_rs2_val  out  DATA_WIDTH  resolved rs2 operand.
- out_imm  out  DATA_WIDTH  sign-extended immediate.
- out_rd  out  REG_ADDR_WIDTH  destination; 0 if the instruction writes no register.
- out_illegal  out  1  opcode not in RV32I base set.

Behaviour:
- Reset (reset low, asynchronous): all registered outputs are 0. in_ready is combinational and held 0 while in reset.
- Source usage:
  - uses_rs1 for OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2 for OP, STORE, BRANCH.
  - LUI, AUIPC and JAL use neither.
- Immediate formats:
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH, bit0 = 0.
  - U: LUI, AUIPC, low 12 bits = 0.
  - J: JAL, bit0 = 0.
  - All formats sign-extend from instr[31]. Other opcodes produce imm 0.
- Operand priority, per source:
  1. Index 0 → 0.
  2. EX forward: ex_fwd_valid && !ex_fwd_is_load && rd match.
  3. WB bypass: wb_we && wb_rd match. Needed because the regfile write lands at the same edge.
  4. Otherwise regfile data.
- Hazard: in_valid && ex_fwd_valid && ex_fwd_is_load && ex_fwd_rd != 0 && a used source matches ex_fwd_rd. Unused source fields never cause a hazard.
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard && !flush.
- On a clock edge with advance && !flush:
  - out_valid <= in_valid && !hazard. A hazard inserts a bubble.
  - Payload registers load only when in_valid && !hazard; otherwise they hold.
- On !advance: all outputs hold, including out_valid. Execute sees stable data.
- flush has priority over everything: out_valid <= 0 at the next edge and the input is not accepted.
- Latency: accepted instruction appears on out_* one cycle later.
- Throughput: 1 per cycle when unstalled.
- rd = 0 writes are reported with out_rd = 0, never forwarded.
- Illegal opcode: passes through with out_illegal = 1, out_rd = 0, imm = 0.

Decomposition:
- Shared package tinyv_pkg:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC).
  - imm_fmt_e enum {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}.
  - id_ex_t struct for the pipeline payload.
- Sub-module imm_gen: combinational (instr, fmt) → imm. It is reused later by branch prediction.

Test Plan:
- Reset with out_valid=1 mid-stream, reset low → out_valid=0 and out_rs1_val=0 immediately; in_ready=0 until release.
- ADDI x5,x0,-1 (0xFFF00293), pc=0x100 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd=5, out_rs1_val=0.
- Forwarding, ADD x3,x1,x2 with regfile x1=1, x2=2:
  - EX fwd x1=0x10 and WB x2=0x20 → out_rs1_val=0x10, out_rs2_val=0x20.
  - EX and WB both target x1 → EX value wins.
- Load-use: EX is a load to x1, instr uses rs1=x1 → in_ready=0, bubble (out_valid=0). Next cycle the load moves to WB (ex_fwd_valid=0, wb_rd=1, wb_data=0x55) → accepted with out_rs1_val=0x55.
- LUI x1 with EX load pending to the instr's rs1 field → no stall. Backpressure: out_ready=0 for 3 cycles → outputs stable, in_ready=0.
- flush while out_valid=1 and in_valid=1 → out_valid=0 next cycle, in_ready=0 that cycle, instruction dropped.
